// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the external-interrupt front end: cause codes,
// CP0 vector addresses, STATUS bit positions and the front-end state encoding.
package intr_ctrl_pkg;

    localparam int NIRQ_MAX = 3;

    localparam int STATUS_IE = 0;

    localparam logic [4:0] CAUSE_BASE = 5'd0;
    localparam logic [4:0] CAUSE_INT0 = 5'd1;

    localparam logic [31:0] VEC_EXC  = 32'h0040_0004;
    localparam logic [31:0] VEC_INT0 = 32'h0040_0008;
    localparam logic [31:0] VEC_INTN = 32'h0040_000c;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        SERVICE = 2'd2
    } state_e;

    // Line i reports cause i+1, so line 0 lands on VEC_INT0 and the rest on VEC_INTN.
    function automatic logic [4:0] cause_of(input int idx);
        return CAUSE_INT0 + 5'(idx);
    endfunction

endpackage

// File: rtl/intr_ctrl_irq_sync.sv
// Per-line synchroniser: two flops to settle the asynchronous request,
// a third flop to detect its rising edge in the clk domain.
module intr_ctrl_irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= irq;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/intr_ctrl.sv
// External-interrupt front end: latches synchronised IRQ edges as pending,
// gates them with STATUS/pipeline state and issues one interrupt at a time to CP0.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NIRQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic [31:0]     status,
    input  logic            exc_in,
    input  logic            eret,
    input  logic            pipe_ready,
    output logic            intr,
    output logic [4:0]      cause,
    output logic            flush,
    output logic            busy,
    output state_e          state_dbg
);

    // intr acts as a one-cycle valid toward CP0 with cause as its payload; CP0 has
    // no back-pressure, and no new intr is offered until eret closes the handler.

    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] pending_next;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] win_oh;
    logic [4:0]      win_cause;
    logic [4:0]      cause_q;
    logic            take;
    state_e          state;
    state_e          state_next;

    logic unused_status;
    assign unused_status = ^status[31:NIRQ+1];

    for (genvar i = 0; i < NIRQ; i++) begin : g_sync
        intr_ctrl_irq_sync u_sync (
            .clk  (clk),
            .rst  (rst),
            .irq  (irq[i]),
            .rise (rise[i])
        );
    end

    assign eligible = pending & status[NIRQ:1];

    // Scan from the top so the lowest eligible index is the last to overwrite.
    always_comb begin
        win_oh    = '0;
        win_cause = CAUSE_BASE;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_cause = cause_of(i);
            end
        end
    end

    assign take = (|eligible) & status[STATUS_IE] & pipe_ready & ~exc_in
                  & (state == IDLE);

    // A fresh edge on the line being issued survives the clear.
    assign pending_next = (pending & ~(take ? win_oh : '0)) | rise;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = ISSUE;
            ISSUE:   state_next = SERVICE;
            SERVICE: if (eret) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pending <= '0;
            cause_q <= CAUSE_BASE;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (take) begin
                cause_q <= win_cause;
            end
        end
    end

    assign intr      = (state == ISSUE);
    assign flush     = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign cause     = cause_q;
    assign state_dbg = state;

endmodule
